cpu_clock_ctrl: RTL and testbench

Programmable CPU clock generator that sits between the board oscillator and the MIPS core. It divides `clk` by a run-time selectable ratio from a parameter table and supports free-run, halt and single-step (one full `clk_N` period per `go` press) modes. It also exports edge strobes and a retired-period counter for the display mux.

---
 rtl/clk_ctrl_pkg.sv | 25 ++
 rtl/sync_edge.sv | 31 +++
 rtl/cpu_clock_ctrl.sv | 137 +++++++++++++
 tb/tb_cpu_clock_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/clk_ctrl_pkg.sv
// Shared types and constants for the CPU clock controller.
// Holds the FSM state encoding, the default divide table and the zero-to-one half-period rule.
package clk_ctrl_pkg;

    typedef enum logic [1:0] {
        StHalt,
        StRun,
        StStep,
        StStop
    } clk_state_e;

    localparam int unsigned DefCntW     = 32;
    localparam int unsigned DefNumRates = 4;
    localparam int unsigned MaxCntW     = 64;

    // Entry 0 is the least-significant slice (10000).
    localparam logic [DefNumRates*DefCntW-1:0] DefDivTable =
        {32'd10000000, 32'd1000000, 32'd100000, 32'd10000};

    // A programmed half-period of 0 would never reach the toggle point, so it runs as 1.
    function automatic logic [MaxCntW-1:0] sat_half(logic [MaxCntW-1:0] val);
        return (val == '0) ? MaxCntW'(1) : val;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser followed by a registered rising-edge detector.
// Intended for raw pushbutton inputs; produces a one-cycle pulse per press.
module sync_edge (
    input  logic clk,
    input  logic clr,
    input  logic din,
    output logic pulse
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic pulse_q;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            pulse_q <= sync2_q & ~prev_q;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/cpu_clock_ctrl.sv
// Programmable CPU clock divider with free-run, halt and single-step modes.
// Exports the divided clock, edge strobes, a retired-period counter and a busy flag.
module cpu_clock_ctrl
    import clk_ctrl_pkg::*;
#(
    parameter int unsigned                      CNT_W     = DefCntW,
    parameter int unsigned                      NUM_RATES = DefNumRates,
    parameter logic [NUM_RATES*CNT_W-1:0]       DIV_TABLE = DefDivTable
) (
    input  logic                         clk,
    input  logic                         clr,
    input  logic                         run,
    input  logic                         go,
    input  logic [$clog2(NUM_RATES)-1:0] rate_sel,
    output logic                         clk_N,
    output logic                         tick_rise,
    output logic                         tick_fall,
    output logic [CNT_W-1:0]             cycle_cnt,
    output logic                         busy
);

    clk_state_e state_q, state_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic             clk_n_q, clk_n_d;
    logic             tick_rise_q, tick_rise_d;
    logic             tick_fall_q, tick_fall_d;

    logic             go_edge;
    logic [CNT_W-1:0] entry;
    logic [CNT_W-1:0] half;
    logic             stall;
    logic             toggle;
    logic             rise_now;

    sync_edge u_go_sync (
        .clk   (clk),
        .clr   (clr),
        .din   (go),
        .pulse (go_edge)
    );

    assign entry = DIV_TABLE[32'(rate_sel)*CNT_W +: CNT_W];
    assign half  = CNT_W'(sat_half(MaxCntW'(entry)));

    // State register
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= StHalt;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StHalt: begin
                if (run) begin
                    state_d = StRun;
                end else if (go_edge) begin
                    state_d = StStep;
                end
            end
            StRun: begin
                if (!run) begin
                    state_d = StStop;
                end
            end
            StStep: begin
                if (toggle && clk_n_q) begin
                    state_d = run ? StRun : StHalt;
                end
            end
            StStop: begin
                if (run) begin
                    state_d = StRun;
                end else if (!clk_n_q || toggle) begin
                    state_d = StHalt;
                end
            end
            default: state_d = StHalt;
        endcase
    end

    // FSM outputs. A low phase is never ended by a rise once run has dropped; the counter
    // holds instead, so re-asserting run in STOP resumes without a reload or short phase.
    always_comb begin
        stall  = (state_q == StRun || state_q == StStop) && !run && !clk_n_q;
        toggle = (state_q != StHalt) && !stall && (cnt_q == CNT_W'(1));
        busy   = (state_q != StHalt);
    end

    // Half-period counter, divided clock, strobes and rise counter
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == StHalt) begin
            cnt_d = (state_d != StHalt) ? half : '0;
        end else if (state_d == StHalt) begin
            cnt_d = '0;
        end else if (toggle) begin
            cnt_d = half;
        end else if (!stall) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        rise_now    = toggle && !clk_n_q;
        clk_n_d     = toggle ? !clk_n_q : clk_n_q;
        tick_rise_d = rise_now;
        tick_fall_d = toggle && clk_n_q;
        cycle_cnt_d = cycle_cnt_q + CNT_W'(rise_now);
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt_q       <= '0;
            clk_n_q     <= 1'b0;
            tick_rise_q <= 1'b0;
            tick_fall_q <= 1'b0;
            cycle_cnt_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            clk_n_q     <= clk_n_d;
            tick_rise_q <= tick_rise_d;
            tick_fall_q <= tick_fall_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign clk_N     = clk_n_q;
    assign tick_rise = tick_rise_q;
    assign tick_fall = tick_fall_q;
    assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Scoreboard bench for cpu_clock_ctrl: stimulus queues expected edge strobes, a monitor checks them.
// Table {8,4,2,0}: rate_sel 0 -> half 1 (0 saturated), 1 -> 2, 2 -> 4, 3 -> 8.
module tb_cpu_clock_ctrl;

    logic       clk;
    logic       clr;
    logic       run;
    logic       go;
    logic [1:0] rate_sel;
    logic       clk_N;
    logic       tick_rise;
    logic       tick_fall;
    logic [7:0] cycle_cnt;
    logic       busy;

    cpu_clock_ctrl #(
        .CNT_W     (8),
        .NUM_RATES (4),
        .DIV_TABLE ({8'd8, 8'd4, 8'd2, 8'd0})
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .run       (run),
        .go        (go),
        .rate_sel  (rate_sel),
        .clk_N     (clk_N),
        .tick_rise (tick_rise),
        .tick_fall (tick_fall),
        .cycle_cnt (cycle_cnt),
        .busy      (busy)
    );

    typedef struct {
        logic       rise;
        logic [7:0] cnt;
        int         gap;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   ref_cyc     = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every strobe must match the next queued expectation, including its spacing.
    always @(negedge clk) begin
        exp_t e;
        if (tick_rise || tick_fall) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_tick: rise=%0b fall=%0b cnt=%0d at cycle %0d",
                         tick_rise, tick_fall, cycle_cnt, cyc);
            end else begin
                e = exp_q.pop_front();
                if (tick_rise !== e.rise || tick_fall !== !e.rise || clk_N !== e.rise ||
                    cycle_cnt !== e.cnt || (cyc - ref_cyc) != e.gap) begin
                    miscompares++;
                    $display("FAIL tick: got rise=%0b fall=%0b clk_N=%0b cnt=%0d gap=%0d, want rise=%0b cnt=%0d gap=%0d",
                             tick_rise, tick_fall, clk_N, cycle_cnt, cyc - ref_cyc,
                             e.rise, e.cnt, e.gap);
                end
            end
            ref_cyc = cyc;
        end
    end

    task automatic push(input logic rise, input logic [7:0] cnt, input int gap);
        exp_t e;
        e.rise = rise;
        e.cnt  = cnt;
        e.gap  = gap;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, act, want);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    // Press go at the current negedge, release three cycles later; STEP is entered at edge 4.
    task automatic press_go();
        go      = 1'b1;
        ref_cyc = cyc + 4;
        wait_neg(3);
        go = 1'b0;
    endtask

    initial begin
        clr      = 1'b0;
        run      = 1'b0;
        go       = 1'b0;
        rate_sel = 2'd0;
        repeat (3) @(negedge clk);
        chk("reset_clk_N", 32'(clk_N), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        clr = 1'b1;
        wait_neg(2);
        chk("reset_clk_N_rel", 32'(clk_N), 32'd0);
        chk("reset_tick_rise", 32'(tick_rise), 32'd0);
        chk("reset_tick_fall", 32'(tick_fall), 32'd0);
        chk("reset_cycle_cnt", 32'(cycle_cnt), 32'd0);
        chk("reset_busy_rel", 32'(busy), 32'd0);

        // Free-run at half 2: rises 2 cycles after entry, period 4
        rate_sel = 2'd1;
        run      = 1'b1;
        ref_cyc  = cyc + 1;
        for (int i = 1; i <= 5; i++) begin
            push(1'b1, 8'(i), 2);
            push(1'b0, 8'(i), 2);
        end
        wait_neg(21);
        chk("run_cnt_after_20", 32'(cycle_cnt), 32'd5);
        chk("run_busy", 32'(busy), 32'd1);
        // Half 1: the phase already loaded keeps 2, then toggles every cycle
        rate_sel = 2'd0;
        push(1'b1, 8'd6, 2);
        push(1'b0, 8'd6, 1);
        push(1'b1, 8'd7, 1);
        push(1'b0, 8'd7, 1);
        push(1'b1, 8'd8, 1);
        push(1'b0, 8'd8, 1);
        wait_neg(7);
        run = 1'b0;
        wait_neg(4);
        chk("stop_low_busy", 32'(busy), 32'd0);
        chk("stop_low_clk_N", 32'(clk_N), 32'd0);
        chk("stop_low_cnt", 32'(cycle_cnt), 32'd8);

        // Single step at half 4; a second press during the high phase is ignored
        rate_sel = 2'd2;
        push(1'b1, 8'd9, 4);
        push(1'b0, 8'd9, 4);
        press_go();
        wait_neg(2);
        chk("step_busy", 32'(busy), 32'd1);
        wait_neg(3);
        chk("step_high", 32'(clk_N), 32'd1);
        go = 1'b1;
        wait_neg(2);
        go = 1'b0;
        wait_neg(22);
        chk("step_done_busy", 32'(busy), 32'd0);
        chk("step_done_clk_N", 32'(clk_N), 32'd0);
        chk("step_done_cnt", 32'(cycle_cnt), 32'd9);

        // Rate change mid-phase completes the current phase, then run=0 while high
        rate_sel = 2'd2;
        run      = 1'b1;
        ref_cyc  = cyc + 1;
        push(1'b1, 8'd10, 4);
        push(1'b0, 8'd10, 4);
        push(1'b1, 8'd11, 8);
        push(1'b0, 8'd11, 8);
        wait_neg(6);
        rate_sel = 2'd3;
        wait_neg(13);
        chk("stop_high_clk_N", 32'(clk_N), 32'd1);
        run = 1'b0;
        wait_neg(10);
        chk("stop_high_busy", 32'(busy), 32'd0);
        chk("stop_high_clk_N_end", 32'(clk_N), 32'd0);
        chk("stop_high_cnt", 32'(cycle_cnt), 32'd11);

        // Counter wrap: 245 rises from 11 ends on 255 -> 0
        rate_sel = 2'd0;
        run      = 1'b1;
        ref_cyc  = cyc + 1;
        for (int n = 1; n <= 245; n++) begin
            push(1'b1, 8'(11 + n), 1);
            push(1'b0, 8'(11 + n), 1);
        end
        wait_neg(491);
        run = 1'b0;
        chk("wrap_cnt", 32'(cycle_cnt), 32'd0);
        wait_neg(5);
        chk("wrap_busy", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of a step high phase
        rate_sel = 2'd2;
        push(1'b1, 8'd1, 4);
        press_go();
        wait_neg(7);
        chk("pre_clr_clk_N", 32'(clk_N), 32'd1);
        clr = 1'b0;
        #1;
        chk("clr_clk_N", 32'(clk_N), 32'd0);
        chk("clr_cycle_cnt", 32'(cycle_cnt), 32'd0);
        chk("clr_busy", 32'(busy), 32'd0);
        wait_neg(3);
        clr = 1'b1;
        wait_neg(20);
        chk("post_clr_busy", 32'(busy), 32'd0);
        chk("post_clr_clk_N", 32'(clk_N), 32'd0);
        push(1'b1, 8'd1, 4);
        push(1'b0, 8'd1, 4);
        press_go();
        wait_neg(15);
        chk("post_clr_step_cnt", 32'(cycle_cnt), 32'd1);
        chk("post_clr_step_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(negedge clk);
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL missing_tick: no strobe seen, want rise=%0b cnt=%0d", e.rise, e.cnt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
